amp_pwr_seq: RTL

- Power/fault sequencer for the class-D speaker amplifiers.
- Holds sht_dwn high until the EQ low-frequency queues are full (seq_low), then waits a warm-up delay before enabling the amps.
- Watches the amps' Flt_n through a synchronizer and glitch filter. On a fault it shuts the amps down, waits a back-off period and retries; after too many retries it locks out until software or a button clears it.
- Sits at Equalizer top level beside spkr_drv; drives the board pin sht_dwn.

---
 rtl/amp_pwr_seq_pkg.sv | 23 ++
 rtl/amp_pwr_seq_if.sv | 34 +++
 rtl/amp_pwr_seq_flt_filter.sv | 42 ++++
 rtl/amp_pwr_seq.sv | 133 +++++++++++++
 4 files changed

// File: rtl/amp_pwr_seq_pkg.sv
// Shared types and default constants for the class-D amplifier power/fault sequencer.
package amp_seq_pkg;

    typedef enum logic [2:0] {
        OFF,
        WARMUP,
        RUN,
        FAULT,
        LOCKOUT
    } amp_state_t;

    localparam int DEF_STARTUP_CYC = 250000;
    localparam int DEF_RETRY_CYC   = 5000000;
    localparam int DEF_FLT_FILT    = 16;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_TMR_W       = 23;

    // Count up by one but never past the given ceiling.
    function automatic logic [1:0] satInc(input logic [1:0] value, input logic [1:0] limit);
        return (value >= limit) ? value : value + 2'd1;
    endfunction

endpackage

// File: rtl/amp_pwr_seq_if.sv
// Control/status bundle between the sequencer and the amplifier board pins / software.
interface amp_pwr_seq_if;

    logic       Flt_n;
    logic       seq_low;
    logic       clr_flt;
    logic       sht_dwn;
    logic       amp_on;
    logic       flt_latched;
    logic [1:0] retry_cnt;

    // Sequencer side: consumes fault/status inputs, drives the shutdown pin and status.
    modport slave (
        input  Flt_n,
        input  seq_low,
        input  clr_flt,
        output sht_dwn,
        output amp_on,
        output flt_latched,
        output retry_cnt
    );

    // Board/software side: the mirror image of the sequencer view.
    modport master (
        output Flt_n,
        output seq_low,
        output clr_flt,
        input  sht_dwn,
        input  amp_on,
        input  flt_latched,
        input  retry_cnt
    );

endinterface

// File: rtl/amp_pwr_seq_flt_filter.sv
// Brings the asynchronous amp fault line into the clock domain and only reports a fault
// once it has been seen low for FLT_FILT consecutive synchronized samples.
module flt_filter #(
    parameter int FLT_FILT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic Flt_n,
    output logic flt_det
);

    localparam int CNT_W = $clog2(FLT_FILT + 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [CNT_W-1:0] r_cnt;

    // Two-flop synchronizer; resets to the idle (no fault) level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= Flt_n;
            r_sync2 <= r_sync1;
        end
    end

    // Count consecutive low samples, saturating at the threshold; any high sample restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_sync2) begin
            r_cnt <= '0;
        end else if (r_cnt != CNT_W'(FLT_FILT)) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    assign flt_det = (r_cnt == CNT_W'(FLT_FILT));

endmodule

// File: rtl/amp_pwr_seq.sv
// Power-up and fault-retry sequencer for the speaker amplifiers: holds the amps in
// shutdown until the EQ queues are full, warms up, runs, and backs off / locks out on faults.
module amp_pwr_seq
    import amp_seq_pkg::*;
#(
    parameter int STARTUP_CYC = DEF_STARTUP_CYC,
    parameter int RETRY_CYC   = DEF_RETRY_CYC,
    parameter int FLT_FILT    = DEF_FLT_FILT,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int TMR_W       = DEF_TMR_W
) (
    input  logic          clk,
    input  logic          rst,
    amp_pwr_seq_if.slave  bus
);

    localparam logic [TMR_W-1:0] STARTUP_TERM = TMR_W'(STARTUP_CYC - 1);
    localparam logic [TMR_W-1:0] RETRY_TERM   = TMR_W'(RETRY_CYC - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRY);

    amp_state_t       r_state;
    logic [TMR_W-1:0] r_timer;
    logic [1:0]       r_retry;
    logic             r_shtDwn;
    logic             r_ampOn;
    logic             r_fltLatched;

    amp_state_t       w_next;
    logic [TMR_W-1:0] w_timerNext;
    logic [1:0]       w_retryNext;
    logic             w_fltDet;
    logic             w_runStable;

    flt_filter #(
        .FLT_FILT (FLT_FILT)
    ) u_fltFilter (
        .clk     (clk),
        .rst     (rst),
        .Flt_n   (bus.Flt_n),
        .flt_det (w_fltDet)
    );

    assign w_runStable = (r_state == RUN) && (r_timer == RETRY_TERM);

    // Next-state, timer and retry-count decisions; outputs are derived from the next state
    // so the status pins move on the same edge as the state register.
    always_comb begin
        w_next      = r_state;
        w_timerNext = r_timer + TMR_W'(1);
        w_retryNext = r_retry;

        case (r_state)
            OFF: begin
                if (bus.seq_low) begin
                    w_next = WARMUP;
                end
            end
            WARMUP: begin
                if (w_fltDet) begin
                    w_next = FAULT;
                end else if (!bus.seq_low) begin
                    w_next = OFF;
                end else if (r_timer == STARTUP_TERM) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                if (w_fltDet) begin
                    w_next = FAULT;
                end
            end
            FAULT: begin
                if (r_timer == RETRY_TERM) begin
                    w_next = (r_retry >= RETRY_LIMIT) ? LOCKOUT : WARMUP;
                end
            end
            LOCKOUT: begin
                if (bus.clr_flt) begin
                    w_next = OFF;
                end
            end
            default: begin
                w_next = OFF;
            end
        endcase

        if (w_next != r_state) begin
            w_timerNext = '0;
        end else if (w_runStable) begin
            w_timerNext = r_timer;
        end

        if ((w_next == FAULT) && (r_state != FAULT)) begin
            w_retryNext = satInc(r_retry, RETRY_LIMIT);
        end else if (w_runStable) begin
            w_retryNext = 2'd0;
        end else if ((r_state == LOCKOUT) && bus.clr_flt) begin
            w_retryNext = 2'd0;
        end
    end

    // State register and timer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= OFF;
            r_timer <= '0;
        end else begin
            r_state <= w_next;
            r_timer <= w_timerNext;
        end
    end

    // Registered status outputs and retry counter, all taken from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shtDwn     <= 1'b1;
            r_ampOn      <= 1'b0;
            r_fltLatched <= 1'b0;
            r_retry      <= 2'd0;
        end else begin
            r_shtDwn     <= (w_next != RUN);
            r_ampOn      <= (w_next == RUN);
            r_fltLatched <= (w_next == LOCKOUT);
            r_retry      <= w_retryNext;
        end
    end

    assign bus.sht_dwn     = r_shtDwn;
    assign bus.amp_on      = r_ampOn;
    assign bus.flt_latched = r_fltLatched;
    assign bus.retry_cnt   = r_retry;

endmodule
